// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply-divide controller.
// Op encoding, datapath width and the MULTU correction term.
package mdu_pkg;

    localparam int DW      = 32;
    localparam int MUL_LAT = 2;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_MTHI  = 3'd2,
        OP_MTLO  = 3'd3,
        OP_MFHI  = 3'd4,
        OP_MFLO  = 3'd5
    } mdu_op_e;

    // unsigned(a*b) = signed(a*b) + 2^DW * corr_f(a, b)  (mod 2^(2*DW))
    function automatic logic [DW:0] corr_f(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        logic [DW:0] ca;
        logic [DW:0] cb;
        ca = a[DW-1] ? {1'b0, b} : '0;
        cb = b[DW-1] ? {1'b0, a} : '0;
        return ca + cb;
    endfunction

endpackage

// File: rtl/mdu_hilo_ctrl_if.sv
// EX-side and multiplier-side bus of the HI/LO controller.
// The controller is the slave; EX plus the multiplier form the master.
interface mdu_hilo_ctrl_if;
    import mdu_pkg::*;

    logic            op_valid;
    logic [2:0]      op;
    logic [DW-1:0]   rs_val;
    logic [DW-1:0]   rt_val;
    logic            op_ready;
    logic [DW-1:0]   mul_a;
    logic [DW-1:0]   mul_b;
    logic [2*DW-1:0] mul_z;
    logic [DW-1:0]   rd_val;
    logic            rd_valid;
    logic            busy;
    logic [DW-1:0]   hi;
    logic [DW-1:0]   lo;

    modport master (
        output op_valid, op, rs_val, rt_val, mul_z,
        input  op_ready, mul_a, mul_b, rd_val, rd_valid,
        input  busy, hi, lo
    );

    modport slave (
        input  op_valid, op, rs_val, rt_val, mul_z,
        output op_ready, mul_a, mul_b, rd_val, rd_valid,
        output busy, hi, lo
    );

endinterface

// File: rtl/mdu_corr_pipe.sv
// Two-stage tracker for in-flight multiplies, shadowing the multiplier.
// Carries valid, the MULTU flag and the signed-to-unsigned correction.
module mdu_corr_pipe
    import mdu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_unsigned,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic          o_v1,
    output logic          o_v2,
    output logic          o_u2,
    output logic [DW:0]   o_corr2
);

    logic          r_v1;
    logic          r_u1;
    logic [DW:0]   r_corr1;
    logic          r_v2;
    logic          r_u2;
    logic [DW:0]   r_corr2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v1    <= 1'b0;
            r_u1    <= 1'b0;
            r_corr1 <= '0;
            r_v2    <= 1'b0;
            r_u2    <= 1'b0;
            r_corr2 <= '0;
        end else begin
            r_v1    <= i_load;
            r_u1    <= i_load & i_unsigned;
            r_corr1 <= corr_f(i_a, i_b);
            r_v2    <= r_v1;
            r_u2    <= r_u1;
            r_corr2 <= r_corr1;
        end
    end

    assign o_v1    = r_v1;
    assign o_v2    = r_v2;
    assign o_u2    = r_u2;
    assign o_corr2 = r_corr2;

endmodule

// File: rtl/mdu_hilo_ctrl.sv
// Issue/writeback controller for the 2-cycle pipelined signed multiplier.
// Owns HI/LO, serves MT/MF and stalls them while a multiply is pending.
module mdu_hilo_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic           clk,
    input  logic           reset,
    mdu_hilo_ctrl_if.slave bus
);

    if (MUL_LAT != 2) begin : g_bad_lat
        $error("mdu_hilo_ctrl supports only MUL_LAT == 2");
    end

    logic            w_is_mul;
    logic            w_is_mtmf;
    logic            w_busy;
    logic            w_ready;
    logic            w_acc;
    logic            w_v1;
    logic            w_v2;
    logic            w_u2;
    logic [DW:0]     w_corr2;
    logic [2*DW:0]   w_sum;
    logic            w_unused_carry;

    logic [DW-1:0]   r_hi;
    logic [DW-1:0]   r_lo;
    logic [DW-1:0]   r_rd_val;
    logic            r_rd_valid;

    // The multiplier free-runs on whatever EX presents.
    assign bus.mul_a = bus.rs_val;
    assign bus.mul_b = bus.rt_val;

    always_comb begin
        w_is_mul  = 1'b0;
        w_is_mtmf = 1'b0;
        unique case (bus.op)
            OP_MULT, OP_MULTU:                 w_is_mul  = 1'b1;
            OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: w_is_mtmf = 1'b1;
            default: ;
        endcase
    end

    assign w_busy  = w_v1 | w_v2;
    assign w_ready = ~(w_is_mtmf & w_busy);
    assign w_acc   = bus.op_valid & w_ready;

    mdu_corr_pipe u_corr (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_acc & w_is_mul),
        .i_unsigned (bus.op == OP_MULTU),
        .i_a        (bus.rs_val),
        .i_b        (bus.rt_val),
        .o_v1       (w_v1),
        .o_v2       (w_v2),
        .o_u2       (w_u2),
        .o_corr2    (w_corr2)
    );

    // Only corr mod 2^DW matters once shifted into the high word.
    assign w_sum = {1'b0, bus.mul_z}
                 + (w_u2 ? {w_corr2, {DW{1'b0}}} : '0);
    assign w_unused_carry = w_sum[2*DW];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_rd_val   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (w_v2) begin
                {r_hi, r_lo} <= w_sum[2*DW-1:0];
            end
            if (w_acc) begin
                unique case (bus.op)
                    OP_MTHI: r_hi <= bus.rs_val;
                    OP_MTLO: r_lo <= bus.rs_val;
                    OP_MFHI: begin
                        r_rd_val   <= r_hi;
                        r_rd_valid <= 1'b1;
                    end
                    OP_MFLO: begin
                        r_rd_val   <= r_lo;
                        r_rd_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.op_ready = w_ready;
    assign bus.busy     = w_busy;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.rd_val   = r_rd_val;
    assign bus.rd_valid = r_rd_valid;

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Bench for mdu_hilo_ctrl: behavioural multiplier plus a queue-based
// reference model of HI/LO, checked every cycle, with literal anchors.
module tb_mdu_hilo_ctrl;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mdu_hilo_ctrl_if u_if ();

    mdu_hilo_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    // Two-stage pipelined signed multiplier.
    logic [63:0] p1;
    logic [63:0] p2;
    always @(posedge clk) begin
        p1 <= $signed({{32{u_if.mul_a[31]}}, u_if.mul_a})
            * $signed({{32{u_if.mul_b[31]}}, u_if.mul_b});
        p2 <= p1;
    end
    assign u_if.mul_z = p2;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending writebacks with their due edge number.
    typedef struct {
        int          due;
        logic [63:0] val;
    } wb_t;

    wb_t         q[$];
    int          cyc = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    logic [31:0] m_rd = 0;
    bit          m_rdv = 1'b0;

    function automatic bit is_mtmf(logic [2:0] o);
        return (o >= 3'd2) && (o <= 3'd5);
    endfunction

    function automatic bit m_ready();
        return !(is_mtmf(u_if.op) && q.size() != 0);
    endfunction

    function automatic logic [63:0] prod(logic [31:0] a, logic [31:0] b, bit u);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (u) return {32'b0, a} * {32'b0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    always @(posedge clk) begin
        bit rdy;
        wb_t e;
        if (!reset) begin
            q.delete();
            m_hi  = '0;
            m_lo  = '0;
            m_rd  = '0;
            m_rdv = 1'b0;
        end else begin
            rdy = m_ready();
            cyc++;
            m_rdv = 1'b0;
            if (q.size() != 0 && q[0].due == cyc) begin
                {m_hi, m_lo} = q[0].val;
                q.delete(0);
            end
            if (u_if.op_valid && rdy) begin
                case (u_if.op)
                    3'd0, 3'd1: begin
                        e.due = cyc + 2;
                        e.val = prod(u_if.rs_val, u_if.rt_val, u_if.op[0]);
                        q.push_back(e);
                    end
                    3'd2: m_hi = u_if.rs_val;
                    3'd3: m_lo = u_if.rs_val;
                    3'd4: begin m_rd = m_hi; m_rdv = 1'b1; end
                    3'd5: begin m_rd = m_lo; m_rdv = 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("op_ready", u_if.op_ready, m_ready());
            chk("busy", u_if.busy, q.size() != 0);
            chk("hi", u_if.hi, m_hi);
            chk("lo", u_if.lo, m_lo);
            chk("rd_valid", u_if.rd_valid, m_rdv);
            chk("rd_val", u_if.rd_val, m_rd);
        end
    end

    task automatic set(bit v, logic [2:0] o, logic [31:0] a, logic [31:0] b);
        u_if.op_valid = v;
        u_if.op       = o;
        u_if.rs_val   = a;
        u_if.rt_val   = b;
        #1;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set(1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0] o;
        int r;
        set(1'b0, 3'd0, 32'd0, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk_en = 1'b1;
        idle();
        chk("rst_hi", u_if.hi, 32'd0);
        chk("rst_lo", u_if.lo, 32'd0);
        chk("rst_rd_valid", u_if.rd_valid, 1'b0);
        chk("rst_rd_val", u_if.rd_val, 32'd0);
        chk("rst_busy", u_if.busy, 1'b0);

        // MULT -1 * 2
        set(1'b1, OP_MULT, 32'hFFFF_FFFF, 32'h2); go();
        idle(); chk("mult_busy_t1", u_if.busy, 1'b1); go();
        chk("mult_busy_t2", u_if.busy, 1'b1); go();
        chk("mult_hi", u_if.hi, 32'hFFFF_FFFF);
        chk("mult_lo", u_if.lo, 32'hFFFF_FFFE);
        chk("mult_busy_t3", u_if.busy, 1'b0);

        // MULTU same operands, then 2^31 * 2^31
        set(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'h2); go();
        idle(); go(); go();
        chk("multu_hi", u_if.hi, 32'h0000_0001);
        chk("multu_lo", u_if.lo, 32'hFFFF_FFFE);
        set(1'b1, OP_MULTU, 32'h8000_0000, 32'h8000_0000); go();
        idle(); go(); go();
        chk("multu_big_hi", u_if.hi, 32'h4000_0000);
        chk("multu_big_lo", u_if.lo, 32'h0);

        // back-to-back
        set(1'b1, OP_MULT, 32'd3, 32'd4); go();
        set(1'b1, OP_MULT, 32'd5, 32'd6); go();
        idle(); go();
        chk("b2b_lo_12", u_if.lo, 32'd12);
        chk("b2b_hi_0", u_if.hi, 32'd0);
        go();
        chk("b2b_lo_30", u_if.lo, 32'd30);
        chk("b2b_hi_0b", u_if.hi, 32'd0);

        // MFLO held behind a multiply
        set(1'b1, OP_MULT, 32'd7, 32'd6); go();
        set(1'b1, OP_MFLO, 32'd0, 32'd0);
        chk("mf_stall_t1", u_if.op_ready, 1'b0); go();
        chk("mf_stall_t2", u_if.op_ready, 1'b0); go();
        chk("mf_ready_t3", u_if.op_ready, 1'b1); go();
        idle();
        chk("mf_rd_valid", u_if.rd_valid, 1'b1);
        chk("mf_rd_val", u_if.rd_val, 32'd42);
        go();
        chk("mf_rd_valid_off", u_if.rd_valid, 1'b0);

        // MTHI then MFHI, then ignored code 7
        set(1'b1, OP_MTHI, 32'h0000_1234, 32'd0); go();
        set(1'b1, OP_MFHI, 32'd0, 32'd0); go();
        idle();
        chk("mthi_rd_valid", u_if.rd_valid, 1'b1);
        chk("mthi_rd_val", u_if.rd_val, 32'h0000_1234);
        go();
        chk("mthi_rd_hold", u_if.rd_val, 32'h0000_1234);
        set(1'b1, 3'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        chk("code7_ready", u_if.op_ready, 1'b1);
        go();
        idle();
        chk("code7_hi", u_if.hi, 32'h0000_1234);
        chk("code7_lo", u_if.lo, 32'd42);
        chk("code7_busy", u_if.busy, 1'b0);

        // reset discards an in-flight multiply
        set(1'b1, OP_MULT, 32'h10, 32'h10); go();
        idle(); reset = 1'b0; go();
        reset = 1'b1;
        chk("rst_mid_hi", u_if.hi, 32'd0);
        chk("rst_mid_lo", u_if.lo, 32'd0);
        chk("rst_mid_busy", u_if.busy, 1'b0);
        go();
        chk("rst_late_lo", u_if.lo, 32'd0);
        chk("rst_late_busy", u_if.busy, 1'b0);
        go();
        chk("rst_late_lo2", u_if.lo, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            o = (r < 4) ? 3'(r % 2) : 3'($urandom_range(2, 7));
            reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            set($urandom_range(0, 3) != 0, o, rnd32(), rnd32());
            go();
        end
        reset = 1'b1;
        idle();
        repeat (4) go();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_hilo_ctrl.md
Name: mdu_hilo_ctrl

Overview:
- Issue and writeback controller for the 2-cycle pipelined signed 32x32 multiplier (module MULT).
- Sits between the EX stage and the multiplier:
  - drives the multiplier operands;
  - tracks multiplies in flight;
  - corrects signed products for MULTU;
  - owns the architectural HI/LO registers;
  - serves MTHI/MTLO/MFHI/MFLO, stalling them while a multiply is pending.

Parameters:
- MUL_LAT, 2, multiplier latency in cycles from operand capture to valid mul_z. The design is fixed at 2; the parameter is documentation only and must equal 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- op_valid  in  1  EX presents an operation.
- op  in  3  operation code (mdu_pkg encoding).
- rs_val  in  32  source operand A, or MTHI/MTLO data.
- rt_val  in  32  source operand B.
- op_ready  out  1  operation accepted this cycle when op_valid is also high.
- mul_a  out  32  multiplier operand a.
- mul_b  out  32  multiplier operand b.
- mul_z  in  64  multiplier signed product.
- rd_val  out  32  MFHI/MFLO result.
- rd_valid  out  1  one-cycle pulse qualifying rd_val.
- busy  out  1  a multiply is in flight.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (reset==0 at a clk edge): hi=0, lo=0, rd_val=0, rd_valid=0, v1=0, v2=0.
  - Reset mid-operation discards every in-flight multiply. No HI/LO write occurs after reset releases.
- Op codes (mdu_pkg): MULT=0, MULTU=1, MTHI=2, MTLO=3, MFHI=4, MFLO=5. Codes 6 and 7 are ignored (accepted, no effect).
- Operand drive: mul_a=rs_val and mul_b=rt_val unconditionally and combinationally. The multiplier free-runs; only the tracking logic qualifies its output.
- Ready rule: combinational.
  - MULT/MULTU are always ready, so back-to-back issue is allowed.
  - MTHI/MTLO/MFHI/MFLO are ready only when busy==0.
- busy = v1 | v2.
- Multiply accepted in cycle t:
  - v1 <= 1 at the end of t. Also captured: u1 = (op==MULTU) and corr1 = (rs[31]?rt:0) + (rt[31]?rs:0), 33 bits, unsigned.
  - At the end of t+1: v2 <= v1, u2 <= u1, corr2 <= corr1.
  - In cycle t+2, mul_z holds the signed product of the t operands.
  - At the end of t+2: {hi,lo} <= mul_z + (u2 ? {corr2[31:0],32'b0} : 0), mod 2^64.
  - New HI/LO values are visible from t+3.
- Correction identity: unsigned product = signed product + 2^32*corr (mod 2^64), where corr = (a[31]?b:0) + (b[31]?a:0).
- Pipeline ordering: stage registers advance every cycle, with no stall. When v1 is not reloaded, v1 <= 0.
- Back-to-back multiplies write HI/LO in issue order, one per cycle. The last issued multiply wins.
- MTHI (accepted in t): hi <= rs_val at the end of t. MTLO: lo <= rs_val.
- MFHI/MFLO (accepted in t): rd_val <= hi or lo at the end of t; rd_valid=1 during t+1 only.
  - rd_val holds its value afterwards.
  - rd_valid is 0 in every cycle without a new MF acceptance.
- Simultaneous events:
  - An MF accepted in the same cycle as a multiply writeback cannot happen, because busy blocks it.
  - A multiply accepted in the cycle its predecessor writes back is legal. Stage 2 writes while stage 1 loads.

Decomposition:
- mdu_pkg holds:
  - op encoding constants (OP_MULT..OP_MFLO);
  - MUL_LAT=2;
  - DW=32.
- One sub-module, mdu_corr_pipe:
  - computes corr from a/b/unsigned flag;
  - carries {valid, unsigned, corr[32:0]} through two register stages;
  - exposes the stage-2 fields.
- The top level holds ready logic, the HI/LO registers, the MF path and the final 64-bit add.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=0x00000002 in cycle t -> busy=1 in t+1 and t+2; from t+3 hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE. Then MULTU 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
- MULT 3*4 at t, then MULT 5*6 at t+1 -> lo=12 at t+3, lo=30 at t+4, hi=0 throughout.
- MULT 7*6 at t with MFLO held from t+1 -> op_ready=0 in t+1 and t+2; MFLO accepted at t+3; rd_valid=1 at t+4 with rd_val=42.
- MTHI 0x00001234 at t, MFHI at t+1 -> rd_val=0x00001234 with rd_valid pulsing in t+2. Code 7 presented -> op_ready=1, no state change.
- MULT 0x10*0x10 at t, reset=0 during t+1, released at t+2 -> hi=lo=0 and busy=0 from t+2 onward; no late write.
